wheel_speed_sampler: RTL and testbench
======================================

Name: wheel_speed_sampler

Overview:
- Periodic sampling scheduler for the four wheel encoder counters. Each input is a free-running 16-bit quadrature count from one encoder counter instance.
- Once per sample period it snapshots all counts simultaneously and computes the signed per-period delta (speed) for each channel.
- It saturates each delta to SPD_W bits and streams the frame one channel at a time over a valid/ready interface to the motor-control / host readout logic.

Parameters:
- N_CH, 4, number of encoder channels
- CNT_W, 16, width of each encoder count input
- SPD_W, 12, signed width of each output speed word (SPD_W <= CNT_W)
- PERIOD, 50000, sample period in clk cycles (>= N_CH+4)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- en  in  1  sampling enable
- enc_count  in  N_CH*CNT_W  packed counts; channel i at [i*CNT_W +: CNT_W]
- spd_data  out  SPD_W  signed speed of the current beat
- spd_ch  out  $clog2(N_CH)  channel index of the current beat
- spd_sat  out  1  current beat was clamped
- spd_last  out  1  current beat is channel N_CH-1
- spd_valid  out  1  beat valid
- spd_ready  in  1  consumer accepts beat
- tick  out  1  one-cycle pulse at each sample instant
- overrun  out  1  sticky: a frame was dropped
- clr_overrun  in  1  clears overrun

Behaviour:
- Reset (reset low, asynchronous): all outputs 0, period counter 0, baselines 0, primed 0, FSM in IDLE.
- Period counter:
  - Counts 0..PERIOD-1 while en=1, then wraps; tick=1 in the cycle where it equals PERIOD-1.
  - en=0 holds the counter at 0, clears primed, and forces tick=0. An in-flight frame still completes.
- Snapshot: on every tick edge, snap[i] <= enc_count[i]. The snapshot is always taken, including while a frame is in flight.
- Primed rule:
  - The first tick after reset, or after en rises, only loads base[i] <= enc_count[i] and sets primed. No frame is produced.
- Delta:
  - raw = (snap[i] - base[i]) mod 2^CNT_W, interpreted as signed CNT_W, so counter wrap-around is handled correctly (0x0003-0xFFFE = +5).
  - Clamp to [-2^(SPD_W-1), 2^(SPD_W-1)-1]. spd_sat=1 for that channel if clamped.
  - base[i] <= snap[i] after each computation.
- FSM states: IDLE, CAPTURE, SEND.
  - IDLE -> CAPTURE on a tick edge with primed=1.
  - CAPTURE (1 cycle): compute and register all N_CH deltas and sat flags, update baselines, then -> SEND with ch=0.
  - SEND: spd_valid=1 and outputs show channel ch. A beat transfers when spd_valid && spd_ready; ch then increments. Transferring the beat with spd_last=1 returns to IDLE.
  - spd_valid rises 2 cycles after the tick edge. Data, ch, sat and last are stable while valid && !ready.
  - The consumer may hold spd_ready high or low indefinitely; there is no timeout.
- Overrun:
  - A tick while the FSM is not IDLE sets overrun. The new snapshot is kept, but no frame is produced and the baselines are not updated.
  - The next accepted frame therefore spans multiple periods. This is intentional: position is never lost.
  - clr_overrun clears overrun. If a set and a clear occur in the same cycle, set wins.
- Simultaneous events: tick and the last-beat handshake in the same cycle counts as an overrun; the FSM is not yet IDLE.

Optional Feature:
- Macro WHEEL_SPEED_AVG_EN.
- Defined:
  - Each channel keeps its previous clamped delta prev[i], reset to 0.
  - Output = (delta + prev) >>> 1, computed at SPD_W+1 bits with arithmetic shift (rounds toward -inf).
  - prev[i] <= delta every frame. spd_sat reflects the current-delta clamp.
  - Latency is unchanged.
- Undefined: the raw clamped delta is output and the prev registers are absent.

Decomposition:
- Package wheel_speed_pkg holds:
  - the state enum (IDLE, CAPTURE, SEND)
  - default N_CH / CNT_W / SPD_W / PERIOD constants
  - function sat_delta(snap, base), returning the clamped value and the sat flag
- One natural sub-module: sample_timer (period counter, en handling, tick generation, primed tracking). The FSM and channel datapath stay in the top level.

Test Plan:
- Prime then step: PERIOD=16, en=1, counts 0. First tick gives no valid. Set ch0=+10, ch1=-3, then next tick -> beats ch0..3 = 10, -3, 0, 0; spd_last on ch3; valid 2 cycles after tick.
- Wrap-around: base 0xFFFC, snap 0x0002 -> +6, no sat. Base 0x0002, snap 0xFFFC -> -6.
- Saturation: delta +3000 -> spd_data=2047, spd_sat=1. Delta -3000 -> -2048, spd_sat=1.
- Backpressure/overrun: spd_ready=0 across the next tick -> data held stable and overrun=1. Release ready -> frame drains. Following frame delta equals 2 periods of motion. clr_overrun -> 0.
- Async reset mid-SEND: drop reset during beat 2 -> spd_valid=0 immediately. After release, the first tick only primes (no frame).
- WHEEL_SPEED_AVG_EN: deltas 10 then 20 -> outputs 5, then 15. Deltas -1 then 0 -> -1 (floor).

Source files
------------

// File: rtl/wheel_speed_pkg.sv
// Shared definitions for the wheel speed sampler: FSM encoding, default sizing
// and the wrap-safe, saturating per-period delta.
package wheel_speed_pkg;

  localparam int DEF_N_CH   = 4;
  localparam int DEF_CNT_W  = 16;
  localparam int DEF_SPD_W  = 12;
  localparam int DEF_PERIOD = 50000;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    SEND
  } state_t;

  localparam logic signed [DEF_CNT_W-1:0] SPD_MAX = DEF_CNT_W'((1 << (DEF_SPD_W - 1)) - 1);
  localparam logic signed [DEF_CNT_W-1:0] SPD_MIN = DEF_CNT_W'(-(1 << (DEF_SPD_W - 1)));

  typedef struct packed {
    logic signed [DEF_SPD_W-1:0] val;
    logic                        sat;
  } sat_res_t;

  // The modular subtraction makes a counter wrap between samples look like a small step.
  function automatic sat_res_t sat_delta(input logic [DEF_CNT_W-1:0] snap,
                                         input logic [DEF_CNT_W-1:0] base);
    sat_res_t                     r;
    logic signed [DEF_CNT_W-1:0]  raw;
    raw   = signed'(snap - base);
    r.sat = 1'b0;
    if (raw > SPD_MAX) begin
      r.val = SPD_MAX[DEF_SPD_W-1:0];
      r.sat = 1'b1;
    end else if (raw < SPD_MIN) begin
      r.val = SPD_MIN[DEF_SPD_W-1:0];
      r.sat = 1'b1;
    end else begin
      r.val = raw[DEF_SPD_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/wheel_speed_sampler_if.sv
// Speed readout stream: one signed speed word per beat, valid/ready handshake.
interface wheel_speed_sampler_if #(
  parameter int SPD_W = 12,
  parameter int CH_W  = 2
);
  logic signed [SPD_W-1:0] spd_data;
  logic [CH_W-1:0]         spd_ch;
  logic                    spd_sat;
  logic                    spd_last;
  logic                    spd_valid;
  logic                    spd_ready;

  modport master (
    output spd_data, spd_ch, spd_sat, spd_last, spd_valid,
    input  spd_ready
  );

  modport slave (
    input  spd_data, spd_ch, spd_sat, spd_last, spd_valid,
    output spd_ready
  );
endinterface

// File: rtl/sample_timer.sv
// Sample period counter: tick on the last count of each period, and primed
// tracking so the first tick after reset or enable only establishes baselines.
module sample_timer import wheel_speed_pkg::*; #(
  parameter int PERIOD = DEF_PERIOD
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick,
  output logic primed
);
  localparam int            CW   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          primed_q, primed_d;

  always_comb begin
    tick     = en && (cnt_q == LAST);
    cnt_d    = cnt_q;
    primed_d = primed_q;
    if (!en) begin
      cnt_d    = '0;
      primed_d = 1'b0;
    end else begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
      if (tick) primed_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      primed_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      primed_q <= primed_d;
    end
  end

  assign primed = primed_q;

endmodule

// File: rtl/wheel_speed_sampler.sv
// Snapshots four encoder counts each sample period and streams saturated speeds.
// Optional WHEEL_SPEED_AVG_EN averages each speed with the previous frame's value.
module wheel_speed_sampler import wheel_speed_pkg::*; #(
  parameter int N_CH   = DEF_N_CH,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int SPD_W  = DEF_SPD_W,
  parameter int PERIOD = DEF_PERIOD
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic [N_CH*CNT_W-1:0]   enc_count,
  wheel_speed_sampler_if.master   spd,
  output logic                    tick,
  output logic                    overrun,
  input  logic                    clr_overrun
);
  localparam int              CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(N_CH - 1);

  logic                    primed;
  logic                    xfer;
  state_t                  state_q, state_d;
  logic [CH_W-1:0]         ch_q, ch_d;
  logic                    overrun_q, overrun_d;
  logic [CNT_W-1:0]        snap_q [N_CH];
  logic [CNT_W-1:0]        snap_d [N_CH];
  logic [CNT_W-1:0]        base_q [N_CH];
  logic [CNT_W-1:0]        base_d [N_CH];
  logic signed [SPD_W-1:0] spd_q  [N_CH];
  logic signed [SPD_W-1:0] spd_d  [N_CH];
  logic                    sat_q  [N_CH];
  logic                    sat_d  [N_CH];
  sat_res_t                res;
`ifdef WHEEL_SPEED_AVG_EN
  logic signed [SPD_W-1:0] prev_q [N_CH];
  logic signed [SPD_W-1:0] prev_d [N_CH];
  logic signed [SPD_W:0]   sum;
`endif

  sample_timer #(.PERIOD(PERIOD)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .tick   (tick),
    .primed (primed)
  );

  always_comb begin : fsm
    state_d   = state_q;
    ch_d      = ch_q;
    overrun_d = overrun_q;
    xfer      = (state_q == SEND) && spd.spd_ready;
    unique case (state_q)
      IDLE:    if (tick && primed) state_d = CAPTURE;
      CAPTURE: begin
        state_d = SEND;
        ch_d    = '0;
      end
      SEND: begin
        if (xfer) begin
          if (ch_q == CH_LAST) begin
            state_d = IDLE;
            ch_d    = '0;
          end else begin
            ch_d = ch_q + CH_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Set wins over clear; a tick landing on the final handshake still counts.
    if (clr_overrun) overrun_d = 1'b0;
    if (tick && primed && (state_q != IDLE)) overrun_d = 1'b1;
  end

  // A dropped frame keeps the old baseline, so the next delta spans every missed period.
  always_comb begin : datapath
    res = '0;
`ifdef WHEEL_SPEED_AVG_EN
    sum = '0;
`endif
    for (int i = 0; i < N_CH; i++) begin
      snap_d[i] = tick ? enc_count[i*CNT_W +: CNT_W] : snap_q[i];
      base_d[i] = base_q[i];
      spd_d[i]  = spd_q[i];
      sat_d[i]  = sat_q[i];
`ifdef WHEEL_SPEED_AVG_EN
      prev_d[i] = prev_q[i];
`endif
      res = sat_delta(snap_q[i], base_q[i]);
      if (tick && !primed) begin
        base_d[i] = enc_count[i*CNT_W +: CNT_W];
      end else if (state_q == CAPTURE) begin
        base_d[i] = snap_q[i];
        sat_d[i]  = res.sat;
`ifdef WHEEL_SPEED_AVG_EN
        sum       = {res.val[SPD_W-1], res.val} + {prev_q[i][SPD_W-1], prev_q[i]};
        spd_d[i]  = sum[SPD_W:1];
        prev_d[i] = res.val;
`else
        spd_d[i]  = res.val;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      ch_q      <= '0;
      overrun_q <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        snap_q[i] <= '0;
        base_q[i] <= '0;
        spd_q[i]  <= '0;
        sat_q[i]  <= 1'b0;
`ifdef WHEEL_SPEED_AVG_EN
        prev_q[i] <= '0;
`endif
      end
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      overrun_q <= overrun_d;
      for (int i = 0; i < N_CH; i++) begin
        snap_q[i] <= snap_d[i];
        base_q[i] <= base_d[i];
        spd_q[i]  <= spd_d[i];
        sat_q[i]  <= sat_d[i];
`ifdef WHEEL_SPEED_AVG_EN
        prev_q[i] <= prev_d[i];
`endif
      end
    end
  end

  assign spd.spd_valid = (state_q == SEND);
  assign spd.spd_data  = spd_q[ch_q];
  assign spd.spd_ch    = ch_q;
  assign spd.spd_sat   = sat_q[ch_q];
  assign spd.spd_last  = (state_q == SEND) && (ch_q == CH_LAST);
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_wheel_speed_sampler.sv
// Directed bench for wheel_speed_sampler with a 16-cycle sample period.
`timescale 1ns/1ps
module tb_wheel_speed_sampler;
  localparam int N_CH = 4, CNT_W = 16, SPD_W = 12, PERIOD = 16;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic                  en = 1'b0;
  logic                  clr_overrun = 1'b0;
  logic [N_CH*CNT_W-1:0] enc_count = '0;
  logic                  tick, overrun;
  int                    passed = 0, total = 0;

  logic signed [SPD_W-1:0] got_d [N_CH];
  logic                    got_s [N_CH];
  logic                    got_l [N_CH];
  logic [1:0]              got_c [N_CH];

  wheel_speed_sampler_if #(.SPD_W(SPD_W), .CH_W(2)) sif ();

  wheel_speed_sampler #(.N_CH(N_CH), .CNT_W(CNT_W), .SPD_W(SPD_W), .PERIOD(PERIOD)) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .enc_count   (enc_count),
    .spd         (sif.master),
    .tick        (tick),
    .overrun     (overrun),
    .clr_overrun (clr_overrun)
  );

  always #5 clk = ~clk;

  task automatic set_enc(input logic [15:0] c0, input logic [15:0] c1,
                         input logic [15:0] c2, input logic [15:0] c3);
    enc_count = {c3, c2, c1, c0};
  endtask

  task automatic wait_tick;
    int n = 0;
    @(negedge clk);
    while (tick !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (tick !== 1'b1) begin
      total++;
      $display("FAIL wait_tick: tick=%b after 64 cycles, want 1", tick);
    end
  endtask

  task automatic collect_frame;
    int n = 0, k = 0;
    while (k < N_CH && n < 40) begin
      if (sif.spd_valid === 1'b1 && sif.spd_ready === 1'b1) begin
        got_d[k] = sif.spd_data;
        got_s[k] = sif.spd_sat;
        got_l[k] = sif.spd_last;
        got_c[k] = sif.spd_ch;
        k++;
      end
      @(negedge clk);
      n++;
    end
    if (k < N_CH) begin
      total++;
      $display("FAIL collect_frame: got %0d beats, want %0d", k, N_CH);
    end
  endtask

  task automatic test_reset;
    int ticks = 0;
    reset = 1'b0; en = 1'b0; sif.spd_ready = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (sif.spd_valid !== 1'b0 || sif.spd_last !== 1'b0 || sif.spd_sat !== 1'b0)
      $display("FAIL reset_flags: valid=%b last=%b sat=%b, want 0 0 0",
               sif.spd_valid, sif.spd_last, sif.spd_sat);
    else passed++;
    total++;
    if (sif.spd_data !== 12'sd0 || sif.spd_ch !== 2'd0)
      $display("FAIL reset_data: data=%0d ch=%0d, want 0 0", sif.spd_data, sif.spd_ch);
    else passed++;
    total++;
    if (tick !== 1'b0 || overrun !== 1'b0)
      $display("FAIL reset_tick_ovr: tick=%b overrun=%b, want 0 0", tick, overrun);
    else passed++;
    reset = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (tick === 1'b1) ticks++;
    end
    total++;
    if (ticks != 0) $display("FAIL en_low_ticks: got %0d ticks, want 0", ticks);
    else passed++;
  endtask

  task automatic test_prime_step;
    int n = 0, vcnt = 0;
    int exp_d [N_CH] = '{10, -3, 0, 0};
    set_enc(16'h0000, 16'h0000, 16'h0000, 16'h0000);
    en = 1'b1;
    while (tick !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n != PERIOD - 1) $display("FAIL first_tick_delay: got %0d cycles, want %0d", n, PERIOD - 1);
    else passed++;
    repeat (5) begin
      @(negedge clk);
      if (sif.spd_valid === 1'b1) vcnt++;
    end
    total++;
    if (vcnt != 0) $display("FAIL prime_no_frame: valid seen %0d cycles, want 0", vcnt);
    else passed++;
    set_enc(16'd10, 16'hFFFD, 16'h0000, 16'h0000);
    wait_tick();
    @(negedge clk);
    total++;
    if (sif.spd_valid !== 1'b0 || tick !== 1'b0)
      $display("FAIL latency_t1: valid=%b tick=%b, want 0 0", sif.spd_valid, tick);
    else passed++;
    @(negedge clk);
    total++;
    if (sif.spd_valid !== 1'b1) $display("FAIL latency_t2: valid=%b, want 1", sif.spd_valid);
    else passed++;
    collect_frame();
    for (int i = 0; i < N_CH; i++) begin
      total++;
      if (got_d[i] !== exp_d[i] || got_s[i] !== 1'b0 || got_c[i] !== 2'(i) || got_l[i] !== (i == N_CH - 1))
        $display("FAIL prime_step beat%0d: data=%0d sat=%b ch=%0d last=%b, want %0d 0 %0d %b",
                 i, got_d[i], got_s[i], got_c[i], got_l[i], exp_d[i], i, (i == N_CH - 1));
      else passed++;
    end
  endtask

  task automatic test_wrap;
    int exp_a [N_CH] = '{-14, 5, 0, 0};
    int exp_b [N_CH] = '{6, -6, 0, 0};
    set_enc(16'hFFFC, 16'h0002, 16'h0000, 16'h0000);
    wait_tick();
    collect_frame();
    for (int i = 0; i < N_CH; i++) begin
      total++;
      if (got_d[i] !== exp_a[i] || got_s[i] !== 1'b0)
        $display("FAIL wrap_a beat%0d: data=%0d sat=%b, want %0d 0", i, got_d[i], got_s[i], exp_a[i]);
      else passed++;
    end
    set_enc(16'h0002, 16'hFFFC, 16'h0000, 16'h0000);
    wait_tick();
    collect_frame();
    for (int i = 0; i < N_CH; i++) begin
      total++;
      if (got_d[i] !== exp_b[i] || got_s[i] !== 1'b0)
        $display("FAIL wrap_b beat%0d: data=%0d sat=%b, want %0d 0", i, got_d[i], got_s[i], exp_b[i]);
      else passed++;
    end
  endtask

  task automatic test_saturation;
    int   exp_d [N_CH] = '{2047, -2048, 2047, -2048};
    logic exp_s [N_CH] = '{1'b0, 1'b0, 1'b1, 1'b1};
    set_enc(16'h0801, 16'hF7FC, 16'h0BB8, 16'hF448);
    wait_tick();
    collect_frame();
    for (int i = 0; i < N_CH; i++) begin
      total++;
      if (got_d[i] !== exp_d[i] || got_s[i] !== exp_s[i])
        $display("FAIL saturation beat%0d: data=%0d sat=%b, want %0d %b",
                 i, got_d[i], got_s[i], exp_d[i], exp_s[i]);
      else passed++;
    end
  endtask

  task automatic test_back_to_back;
    int exp_a [N_CH] = '{7, 0, 0, 0};
    int exp_b [N_CH] = '{14, 0, 0, 0};
    sif.spd_ready = 1'b0;
    set_enc(16'h0808, 16'hF7FC, 16'h0BB8, 16'hF448);
    wait_tick();
    @(negedge clk);
    @(negedge clk);
    total++;
    if (sif.spd_valid !== 1'b1 || sif.spd_data !== 12'sd7 || sif.spd_ch !== 2'd0)
      $display("FAIL stall_first: valid=%b data=%0d ch=%0d, want 1 7 0",
               sif.spd_valid, sif.spd_data, sif.spd_ch);
    else passed++;
    set_enc(16'h080F, 16'hF7FC, 16'h0BB8, 16'hF448);
    wait_tick();
    total++;
    if (sif.spd_valid !== 1'b1 || sif.spd_data !== 12'sd7 || sif.spd_ch !== 2'd0 || sif.spd_last !== 1'b0)
      $display("FAIL stall_hold: valid=%b data=%0d ch=%0d last=%b, want 1 7 0 0",
               sif.spd_valid, sif.spd_data, sif.spd_ch, sif.spd_last);
    else passed++;
    @(negedge clk);
    total++;
    if (overrun !== 1'b1) $display("FAIL overrun_set: overrun=%b, want 1", overrun);
    else passed++;
    sif.spd_ready = 1'b1;
    collect_frame();
    for (int i = 0; i < N_CH; i++) begin
      total++;
      if (got_d[i] !== exp_a[i] || got_c[i] !== 2'(i))
        $display("FAIL drain beat%0d: data=%0d ch=%0d, want %0d %0d", i, got_d[i], got_c[i], exp_a[i], i);
      else passed++;
    end
    total++;
    if (sif.spd_valid !== 1'b0) $display("FAIL dropped_frame: valid=%b, want 0", sif.spd_valid);
    else passed++;
    set_enc(16'h0816, 16'hF7FC, 16'h0BB8, 16'hF448);
    wait_tick();
    collect_frame();
    for (int i = 0; i < N_CH; i++) begin
      total++;
      if (got_d[i] !== exp_b[i] || got_s[i] !== 1'b0)
        $display("FAIL two_period beat%0d: data=%0d sat=%b, want %0d 0", i, got_d[i], got_s[i], exp_b[i]);
      else passed++;
    end
    total++;
    if (overrun !== 1'b1) $display("FAIL overrun_sticky: overrun=%b, want 1", overrun);
    else passed++;
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    total++;
    if (overrun !== 1'b0) $display("FAIL overrun_clear: overrun=%b, want 0", overrun);
    else passed++;
  endtask

  task automatic test_async_reset;
    int vcnt = 0;
    int exp_d [N_CH] = '{3, 0, 0, 0};
    set_enc(16'h081B, 16'hF7FC, 16'h0BB8, 16'hF448);
    wait_tick();
    repeat (3) @(negedge clk);
    total++;
    if (sif.spd_valid !== 1'b1 || sif.spd_ch !== 2'd1)
      $display("FAIL beat2_reached: valid=%b ch=%0d, want 1 1", sif.spd_valid, sif.spd_ch);
    else passed++;
    #1 reset = 1'b0;
    #1;
    total++;
    if (sif.spd_valid !== 1'b0 || sif.spd_ch !== 2'd0 || sif.spd_data !== 12'sd0)
      $display("FAIL async_reset: valid=%b ch=%0d data=%0d, want 0 0 0",
               sif.spd_valid, sif.spd_ch, sif.spd_data);
    else passed++;
    @(negedge clk);
    reset = 1'b1;
    wait_tick();
    repeat (5) begin
      @(negedge clk);
      if (sif.spd_valid === 1'b1) vcnt++;
    end
    total++;
    if (vcnt != 0) $display("FAIL reprime_no_frame: valid seen %0d cycles, want 0", vcnt);
    else passed++;
    set_enc(16'h081E, 16'hF7FC, 16'h0BB8, 16'hF448);
    wait_tick();
    collect_frame();
    for (int i = 0; i < N_CH; i++) begin
      total++;
      if (got_d[i] !== exp_d[i] || got_s[i] !== 1'b0)
        $display("FAIL after_reset beat%0d: data=%0d sat=%b, want %0d 0", i, got_d[i], got_s[i], exp_d[i]);
      else passed++;
    end
  endtask

  task automatic test_avg;
    logic [15:0] cnt [5] = '{16'd10, 16'd30, 16'd30, 16'd29, 16'd29};
    int          exp [5] = '{5, 15, 10, -1, -1};
    set_enc(16'h0000, 16'h0000, 16'h0000, 16'h0000);
    en = 1'b1;
    wait_tick();
    @(negedge clk);
    for (int f = 0; f < 5; f++) begin
      set_enc(cnt[f], 16'h0000, 16'h0000, 16'h0000);
      wait_tick();
      collect_frame();
      total++;
      if (got_d[0] !== exp[f] || got_s[0] !== 1'b0 || got_d[1] !== 12'sd0 || got_d[3] !== 12'sd0)
        $display("FAIL avg frame%0d: ch0=%0d sat=%b ch1=%0d ch3=%0d, want %0d 0 0 0",
                 f, got_d[0], got_s[0], got_d[1], got_d[3], exp[f]);
      else passed++;
    end
  endtask

  initial begin
    sif.spd_ready = 1'b1;
    test_reset();
`ifdef WHEEL_SPEED_AVG_EN
    test_avg();
`else
    test_prime_step();
    test_wrap();
    test_saturation();
    test_back_to_back();
    test_async_reset();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
